// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter: latches up to IRQ_COUNT interrupt sources and presents one
// fixed-priority (lowest index first) vector to the control unit until it is acknowledged.
module irq_priority_arbiter #(
  parameter int                    IRQ_COUNT     = 8,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    I_ADDR_WIDTH  = 10,
  parameter int                    VECTOR_STRIDE = 1,
  parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR     = 16'h003A,
  parameter logic [ADDR_WIDTH-1:0] MASK_ADDR     = 16'h003B,
  parameter logic [ADDR_WIDTH-1:0] EDGE_ADDR     = 16'h0039
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IRQ_COUNT-1:0]    irq_src,
  input  logic                    global_ie,
  output logic                    irq,
  output logic [I_ADDR_WIDTH-1:0] vector,
  input  logic                    ack,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  inout  wire  [DATA_WIDTH-1:0]   bus_data,
  input  logic                    io_cs,
  input  logic                    io_we,
  input  logic                    io_oe
);

  localparam int IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [IRQ_COUNT-1:0]    r_sync1, r_sync2, r_prev;
  logic [IRQ_COUNT-1:0]    r_iflg, r_imsk, r_iedg;
  state_t                  r_state;
  logic [IDX_W-1:0]        r_grant_idx;
  logic [I_ADDR_WIDTH-1:0] r_vector;

  logic [IRQ_COUNT-1:0]    w_set, w_sw_clr, w_hw_clr, w_cand, w_wdata;
  logic                    w_wr_flag, w_wr_mask, w_wr_edge, w_rd_en, w_addr_hit;
  logic                    w_cand_any, w_grant_live;
  logic [IDX_W-1:0]        w_pri_idx;
  logic [I_ADDR_WIDTH-1:0] w_vec_next;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [IRQ_COUNT-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Bus decode, pending set/clear terms and priority selection.
  always_comb begin
    w_wdata      = bus_data[IRQ_COUNT-1:0];
    w_wr_flag    = io_cs & io_we & (bus_addr == FLAG_ADDR);
    w_wr_mask    = io_cs & io_we & (bus_addr == MASK_ADDR);
    w_wr_edge    = io_cs & io_we & (bus_addr == EDGE_ADDR);
    w_rd_en      = io_cs & io_oe;
    w_set        = (r_iedg & r_sync2 & ~r_prev) | (~r_iedg & r_sync2);
    w_sw_clr     = w_wr_flag ? w_wdata : {IRQ_COUNT{1'b0}};
    w_hw_clr     = ((r_state == S_REQ) && ack) ? (IRQ_COUNT'(1) << r_grant_idx)
                                               : {IRQ_COUNT{1'b0}};
    w_cand       = r_iflg & r_imsk;
    w_cand_any   = |w_cand;
    w_pri_idx    = lowest_set(w_cand);
    w_grant_live = w_cand[r_grant_idx];
    // Slot 0 holds the reset vector, so source n maps to slot n+1.
    w_vec_next   = I_ADDR_WIDTH'((32'(w_pri_idx) + 32'd1) * 32'(VECTOR_STRIDE));
  end

  // Register read mux; unimplemented upper bits read as zero.
  always_comb begin
    w_rd_data  = {DATA_WIDTH{1'b0}};
    w_addr_hit = 1'b0;
    case (bus_addr)
      FLAG_ADDR: begin
        w_rd_data  = DATA_WIDTH'(r_iflg);
        w_addr_hit = 1'b1;
      end
      MASK_ADDR: begin
        w_rd_data  = DATA_WIDTH'(r_imsk);
        w_addr_hit = 1'b1;
      end
      EDGE_ADDR: begin
        w_rd_data  = DATA_WIDTH'(r_iedg);
        w_addr_hit = 1'b1;
      end
      default: begin
        w_rd_data  = {DATA_WIDTH{1'b0}};
        w_addr_hit = 1'b0;
      end
    endcase
  end

  assign bus_data = (w_rd_en & w_addr_hit) ? w_rd_data : {DATA_WIDTH{1'bz}};

  // Two-flop synchronizer plus history flop, independent of the edge/level mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= {IRQ_COUNT{1'b0}};
      r_sync2 <= {IRQ_COUNT{1'b0}};
      r_prev  <= {IRQ_COUNT{1'b0}};
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Pending flags (set wins over clear) and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iflg <= {IRQ_COUNT{1'b0}};
      r_imsk <= {IRQ_COUNT{1'b0}};
      r_iedg <= {IRQ_COUNT{1'b1}};
    end else begin
      r_iflg <= (r_iflg & ~(w_sw_clr | w_hw_clr)) | w_set;
      r_imsk <= w_wr_mask ? w_wdata : r_imsk;
      r_iedg <= w_wr_edge ? w_wdata : r_iedg;
    end
  end

  // Grant FSM: the vector is frozen from IDLE until the request resolves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant_idx <= {IDX_W{1'b0}};
      r_vector    <= {I_ADDR_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (global_ie && w_cand_any) begin
            r_grant_idx <= w_pri_idx;
            r_vector    <= w_vec_next;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) begin
            r_state <= S_DONE;
          end else if (!w_grant_live) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq    = (r_state == S_REQ) & global_ie;
  assign vector = r_vector;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Randomized bench for irq_priority_arbiter against a cycle-level behavioural model
// built from pending/mask/priority rules, with a few directed scenarios up front.
`timescale 1ns/1ps
module tb_irq_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic       global_ie;
  logic       irq;
  logic [9:0] vector;
  logic       ack;
  logic [15:0] bus_addr;
  tri1  [7:0] bus_data;
  logic       io_cs, io_we, io_oe;
  logic       tb_drv;
  logic [7:0] tb_wdata;

  assign bus_data = tb_drv ? tb_wdata : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  irq_priority_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .global_ie (global_ie),
    .irq       (irq),
    .vector    (vector),
    .ack       (ack),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .io_cs     (io_cs),
    .io_we     (io_we),
    .io_oe     (io_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Staged inputs for the next cycle.
  logic       d_reset, d_gie, d_ack, d_cs, d_we, d_oe;
  logic [7:0] d_src, d_wdata;
  logic [15:0] d_addr;

  // Reference model state.
  logic [7:0] m_flg, m_msk, m_edg;
  logic [7:0] m_hist [3];
  bit         m_busy, m_cool;
  int         m_grant;
  logic [9:0] m_vec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flg   = 8'h00;
    m_msk   = 8'h00;
    m_edg   = 8'hFF;
    for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
    m_busy  = 1'b0;
    m_cool  = 1'b0;
    m_grant = 0;
    m_vec   = 10'd0;
  endtask

  task automatic model_edge();
    logic [7:0] nflg, cand;
    bit         hit;
    nflg = m_flg;
    cand = m_flg & m_msk;
    if (d_cs && d_we && d_addr == 16'h003A) nflg = nflg & ~d_wdata;
    if (m_busy && d_ack) nflg[m_grant] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit = m_edg[i] ? (m_hist[1][i] && !m_hist[2][i]) : m_hist[1][i];
      if (hit) nflg[i] = 1'b1;
    end
    if (m_busy) begin
      if (d_ack) begin
        m_busy = 1'b0;
        m_cool = 1'b1;
      end else if (!cand[m_grant]) begin
        m_busy = 1'b0;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (d_gie && cand != 8'h00) begin
      for (int i = 7; i >= 0; i--) if (cand[i]) m_grant = i;
      m_vec  = 10'(m_grant + 1);
      m_busy = 1'b1;
    end
    if (d_cs && d_we && d_addr == 16'h003B) m_msk = d_wdata;
    if (d_cs && d_we && d_addr == 16'h0039) m_edg = d_wdata;
    m_flg     = nflg;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = d_src;
  endtask

  function automatic logic [7:0] exp_bus();
    if (d_cs && d_oe) begin
      case (d_addr)
        16'h003A: return m_flg;
        16'h003B: return m_msk;
        16'h0039: return m_edg;
        default:  return 8'hFF;
      endcase
    end
    return 8'hFF;
  endfunction

  task automatic idle_bus();
    d_ack   = 1'b0;
    d_cs    = 1'b0;
    d_we    = 1'b0;
    d_oe    = 1'b0;
    d_addr  = 16'h0000;
    d_wdata = 8'h00;
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    reset     = d_reset;
    irq_src   = d_src;
    global_ie = d_gie;
    ack       = d_ack;
    io_cs     = d_cs;
    io_we     = d_we;
    io_oe     = d_oe;
    bus_addr  = d_addr;
    tb_wdata  = d_wdata;
    tb_drv    = d_cs & d_we;
    if (d_reset) model_reset();
    #1;
    check_eq("irq", {31'd0, irq}, {31'd0, m_busy & d_gie});
    check_eq("vector", {22'd0, vector}, {22'd0, m_vec});
    if (!tb_drv) check_eq("bus_data", {24'd0, bus_data}, {24'd0, exp_bus()});
    @(posedge clk);
    if (!d_reset) model_edge();
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    d_cs = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data;
    step();
    idle_bus();
  endtask

  task automatic rd(input logic [15:0] addr);
    d_cs = 1'b1; d_oe = 1'b1; d_addr = addr;
    step();
    idle_bus();
  endtask

  logic [15:0] addr_tbl [5];

  initial begin
    addr_tbl = '{16'h0039, 16'h003A, 16'h003B, 16'h0038, 16'h013A};
    reset = 1'b1; irq_src = 8'h00; global_ie = 1'b0; ack = 1'b0;
    io_cs = 1'b0; io_we = 1'b0; io_oe = 1'b0; bus_addr = 16'h0000;
    tb_drv = 1'b0; tb_wdata = 8'h00;
    idle_bus();
    d_reset = 1'b1; d_src = 8'h00; d_gie = 1'b1;
    model_reset();

    // Reset state, including register read-back.
    rd(16'h0039);
    rd(16'h003A);
    d_reset = 1'b0;
    step();

    // Edge source 2 with IMSK=04: irq four edges after the pulse, vector 3.
    wr(16'h003B, 8'h04);
    d_src = 8'h04; step();
    d_src = 8'h00; step(); step(); step();
    #1;
    check_eq("edge_irq", {31'd0, irq}, 32'd1);
    check_eq("edge_vec", {22'd0, vector}, 32'd3);
    d_ack = 1'b1; step(); d_ack = 1'b0;
    #1;
    check_eq("ack_irq_low", {31'd0, irq}, 32'd0);
    rd(16'h003A);

    // Simultaneous sources 5 and 1: vector 2 first, vector 6 three edges after ack.
    wr(16'h003B, 8'hFF);
    d_src = 8'h22; step();
    d_src = 8'h00; step(); step(); step();
    #1;
    check_eq("prio_vec", {22'd0, vector}, 32'd2);
    d_ack = 1'b1; step(); d_ack = 1'b0;
    step(); step();
    #1;
    check_eq("next_irq", {31'd0, irq}, 32'd1);
    check_eq("next_vec", {22'd0, vector}, 32'd6);

    // Reset while requesting: everything back to reset values at once.
    d_reset = 1'b1; d_cs = 1'b1; d_oe = 1'b1; d_addr = 16'h003B;
    step();
    #1;
    check_eq("rst_vec", {22'd0, vector}, 32'd0);
    check_eq("rst_imsk", {24'd0, bus_data}, 32'd0);
    idle_bus();
    d_reset = 1'b0;
    step();

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int op;
      idle_bus();
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) d_src[b] = ~d_src[b];
      d_gie   = ($urandom_range(0, 9) != 0);
      d_ack   = ($urandom_range(0, 3) == 0);
      d_reset = ($urandom_range(0, 799) == 0);
      d_addr  = addr_tbl[$urandom_range(0, 4)];
      op      = $urandom_range(0, 9);
      if (op <= 3) begin
        d_cs = $urandom_range(0, 1) != 0;
        d_oe = !d_cs && ($urandom_range(0, 1) != 0);
      end else if (op <= 6) begin
        d_cs = 1'b1; d_oe = 1'b1;
      end else begin
        d_cs = 1'b1; d_we = 1'b1; d_wdata = 8'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
